// File: rtl/duty_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// duty_cycle_ctrl
//
// Turns two raw push-buttons (up/down) into the registered 4-bit duty word
// consumed by the PWM generator. Each button goes through a 2-flop
// synchronizer, a debounce counter and a press-edge FSM. Accepted presses
// step a saturating duty register by one.
//
// Optional build macro: DUTY_AUTOREPEAT_EN
//   When defined, a held button produces extra press events: the first one
//   REPEAT_DELAY cycles after the button FSM enters PRESSED, then one every
//   REPEAT_PERIOD cycles until release. When undefined, the repeat logic and
//   its parameters do not exist.
//
// Ports:
//   clk         in   system clock, everything on the rising edge
//   reset       in   synchronous, active-high reset
//   btn_up      in   raw asynchronous up button, 1 = pressed
//   btn_down    in   raw asynchronous down button, 1 = pressed
//   duty_cycle  out  [3:0] registered duty value
//   at_max      out  registered, 1 when duty_cycle == 15
//   at_min      out  registered, 1 when duty_cycle == 0
//   step        out  registered one-cycle strobe on the edge duty_cycle changed
//
// Output handshake: step acts as a valid strobe with no ready. It is high for
// exactly the one cycle following the edge on which duty_cycle/at_max/at_min
// took a new value; those three outputs are stable and meaningful whenever
// step is high, and a consumer that misses the strobe loses nothing because
// the values themselves stay registered.
// -----------------------------------------------------------------------------
module duty_cycle_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 16,
`ifdef DUTY_AUTOREPEAT_EN
    parameter int         REPEAT_DELAY    = 1000,
    parameter int         REPEAT_PERIOD   = 250,
`endif
    parameter logic [3:0] DUTY_INIT       = 4'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] duty_cycle,
    output logic       at_max,
    output logic       at_min,
    output logic       step
);

    typedef enum logic {
        BTN_RELEASED = 1'b0,
        BTN_PRESSED  = 1'b1
    } btn_state_e;

    // Counter value at which a differing sample run is accepted as the new
    // level: DEBOUNCE_CYCLES consecutive differing samples in total.
    localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]  DUTY_MAX = 4'd15;
    localparam logic [3:0]  DUTY_MIN = 4'd0;

    // Bit 0 = up button, bit 1 = down button throughout.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] press_evt;

    assign btn_raw = {btn_down, btn_up};

    // Two-flop synchronizer; sync2_q is the only internal view of the buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [15:0] db_cnt_q;
        logic        db_lvl_q;
        btn_state_e  state_q;
        btn_state_e  state_d;
        logic        press_d;
        logic        press_q;

        // Debounce: count consecutive samples that disagree with the accepted
        // level; any agreeing sample restarts the count.
        always_ff @(posedge clk) begin
            if (reset) begin
                db_cnt_q <= '0;
                db_lvl_q <= 1'b0;
            end else if (sync2_q[i] != db_lvl_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_lvl_q <= sync2_q[i];
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 16'd1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end

`ifdef DUTY_AUTOREPEAT_EN
        localparam logic [31:0] RPT_FIRST = 32'(REPEAT_DELAY - 1);
        localparam logic [31:0] RPT_NEXT  = 32'(REPEAT_PERIOD - 1);

        logic [31:0] hold_cnt_q;
        logic        rpt_phase_q;   // 0 = waiting for first repeat, 1 = periodic
        logic        rpt_fire;

        // press_q is registered, so firing at count N-1 lands the duty update
        // exactly N cycles after the duty update of the original press.
        always_comb begin
            rpt_fire = 1'b0;
            if (state_q == BTN_PRESSED && db_lvl_q) begin
                rpt_fire = rpt_phase_q ? (hold_cnt_q == RPT_NEXT)
                                       : (hold_cnt_q == RPT_FIRST);
            end
        end

        always_ff @(posedge clk) begin
            if (reset || state_q != BTN_PRESSED) begin
                hold_cnt_q  <= '0;
                rpt_phase_q <= 1'b0;
            end else if (rpt_fire) begin
                hold_cnt_q  <= '0;
                rpt_phase_q <= 1'b1;
            end else begin
                hold_cnt_q  <= hold_cnt_q + 32'd1;
            end
        end
`endif

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= BTN_RELEASED;
                press_q <= 1'b0;
            end else begin
                state_q <= state_d;
                press_q <= press_d;
            end
        end

        // The FSM state always trails the debounced level by one cycle, so
        // "RELEASED with level high" is exactly the debounced 0->1 transition.
        always_comb begin
            state_d = state_q;
            press_d = 1'b0;
            case (state_q)
                BTN_RELEASED: begin
                    if (db_lvl_q) begin
                        state_d = BTN_PRESSED;
                        press_d = 1'b1;
                    end
                end
                BTN_PRESSED: begin
                    if (!db_lvl_q) begin
                        state_d = BTN_RELEASED;
                    end
`ifdef DUTY_AUTOREPEAT_EN
                    if (rpt_fire) begin
                        press_d = 1'b1;
                    end
`endif
                end
                default: state_d = BTN_RELEASED;
            endcase
        end

        assign press_evt[i] = press_q;
    end

    // Duty update: opposing events cancel, saturation never wraps.
    logic [3:0] duty_q;
    logic [3:0] duty_d;
    logic       step_d;

    always_comb begin
        duty_d = duty_q;
        step_d = 1'b0;
        if (press_evt[0] && !press_evt[1] && duty_q != DUTY_MAX) begin
            duty_d = duty_q + 4'd1;
            step_d = 1'b1;
        end else if (press_evt[1] && !press_evt[0] && duty_q != DUTY_MIN) begin
            duty_d = duty_q - 4'd1;
            step_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q <= DUTY_INIT;
            at_max <= (DUTY_INIT == DUTY_MAX);
            at_min <= (DUTY_INIT == DUTY_MIN);
            step   <= 1'b0;
        end else begin
            duty_q <= duty_d;
            at_max <= (duty_d == DUTY_MAX);
            at_min <= (duty_d == DUTY_MIN);
            step   <= step_d;
        end
    end

    assign duty_cycle = duty_q;

endmodule

// File: tb/tb_duty_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_duty_cycle_ctrl
//
// Directed bench for duty_cycle_ctrl with DEBOUNCE_CYCLES=4, DUTY_INIT=8.
// Stimulus tasks push the expected {cycle, duty, at_max, at_min} of every step
// strobe into exp_q; an independent monitor pops and compares on each step.
// -----------------------------------------------------------------------------
module tb_duty_cycle_ctrl;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;   // raw edge E0 -> duty change at E0+LAT
    localparam int W   = 38;       // 32-bit cycle + 4-bit duty + max + min

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic [3:0] duty_cycle;
    logic       at_max;
    logic       at_min;
    logic       step;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    duty_cycle_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .DUTY_INIT      (4'd8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .duty_cycle(duty_cycle),
        .at_max    (at_max),
        .at_min    (at_min),
        .step      (step)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] pack_exp(input int c, input logic [3:0] d);
        return {32'(c), d, (d == 4'd15), (d == 4'd0)};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [W-1:0] got;
        logic [W-1:0] e;
        if (step) begin
            n_checks++;
            got = {32'(cyc), duty_cycle, at_max, at_min};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL step_unexpected: step at cycle %0d duty %0d, no step required",
                         cyc, duty_cycle);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL step_compare: got cyc=%0d duty=%0d max=%0b min=%0b, required cyc=%0d duty=%0d max=%0b min=%0b",
                             got[37:6], got[5:2], got[1], got[0],
                             e[37:6], e[5:2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drive the buttons for `hold` cycles, release, let everything settle,
    // then check the settled outputs and that no required step is pending.
    task automatic press(input logic up, input logic dn, input int hold,
                         input logic exp_step, input logic [3:0] exp_duty,
                         input string name);
        @(negedge clk);
        btn_up   = up;
        btn_down = dn;
        if (exp_step) exp_q.push_back(pack_exp(cyc + LAT + 1, exp_duty));
        repeat (hold) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (14) @(negedge clk);
        chk({name, "_duty"},    32'(duty_cycle), 32'(exp_duty));
        chk({name, "_at_max"},  32'(at_max),     32'(exp_duty == 4'd15));
        chk({name, "_at_min"},  32'(at_min),     32'(exp_duty == 4'd0));
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic glitch_train();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            btn_up = 1'b1;
            repeat (2) @(negedge clk);
            btn_up = 1'b0;
            repeat (1) @(negedge clk);
        end
        repeat (14) @(negedge clk);
        chk("glitch_duty", 32'(duty_cycle), 32'd8);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_duty",   32'(duty_cycle), 32'd8);
        chk("reset_at_max", 32'(at_max),     32'd0);
        chk("reset_at_min", 32'(at_min),     32'd0);
        chk("reset_step",   32'(step),       32'd0);
        reset = 1'b0;

        // Idle after reset release: nothing moves.
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("idle_duty", 32'(duty_cycle), 32'd8);
            chk("idle_step", 32'(step),       32'd0);
        end

        // Bounce shorter than the debounce window is ignored.
        glitch_train();

        // Clean long press: 8 -> 9 at E0+7.
        press(1'b1, 1'b0, 20, 1'b1, 4'd9, "up_long");

        // Walk up to the top, then saturation and cancellation at 15.
        for (int k = 10; k <= 15; k++) press(1'b1, 1'b0, 12, 1'b1, 4'(k), "up_walk");
        press(1'b1, 1'b0, 12, 1'b0, 4'd15, "up_sat");
        press(1'b1, 1'b1, 12, 1'b0, 4'd15, "both_max");

        // Walk down to the bottom, then saturation and cancellation at 0.
        for (int k = 14; k >= 0; k--) press(1'b0, 1'b1, 12, 1'b1, 4'(k), "down_walk");
        press(1'b0, 1'b1, 12, 1'b0, 4'd0, "down_sat");
        press(1'b1, 1'b1, 12, 1'b0, 4'd0, "both_min");
        press(1'b1, 1'b0, 12, 1'b1, 4'd1, "up_from_min");

        // Reset in the middle of an up debounce, button held through release.
        @(negedge clk);
        btn_up = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset_duty", 32'(duty_cycle), 32'd8);
        chk("midreset_step", 32'(step),       32'd0);
        reset = 1'b0;
        exp_q.push_back(pack_exp(cyc + LAT + 1, 4'd9));
        repeat (12) @(negedge clk);
        btn_up = 1'b0;
        repeat (14) @(negedge clk);
        chk("midreset_after_duty", 32'(duty_cycle), 32'd9);

        // Final report.
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
